// File: rtl/flit_injector.sv
// Packetizing source for a router node input port: turns a (dst, len) descriptor
// plus a payload word stream into a HEADER / BODY... / TAIL wormhole packet.

package flit_injector_pkg;
  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } addr_t;

  localparam logic [1:0] FT_HEADER = 2'd1;
  localparam logic [1:0] FT_BODY   = 2'd2;
  localparam logic [1:0] FT_TAIL   = 2'd3;

  typedef struct packed {
    addr_t dst_addr;
    addr_t src_addr;
  } control_hdr_t;

  typedef struct packed {
    logic [1:0]           ftype;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;
endpackage

interface node_port;
  import flit_injector_pkg::*;
  flit_t flit;
  logic  enable;
  logic  ack;
  modport up   (output flit, output enable, input ack);
  modport down (input flit, input enable, output ack);
endinterface

module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int X     = 1,
  parameter int Y     = 1,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  addr_t                msg_dst,
  input  logic [LEN_W-1:0]     msg_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [PAYLOAD_W-1:0] data,
  node_port.up                 out,
  output logic                 err_self,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, BODY, ZTAIL} state_t;

  localparam addr_t SELF = '{x: COORD_W'(X), y: COORD_W'(Y)};

  state_t            state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  flit_t             slot, load_flit;
  logic              sv, free, load, self_drop;
  control_hdr_t      hdr;

  // The slot can take a new flit when empty or when its current flit leaves this cycle.
  assign free = !sv || out.ack;

  always_comb begin
    hdr          = '0;
    hdr.dst_addr = msg_dst;
  end

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    load       = 1'b0;
    load_flit  = '0;
    msg_ready  = 1'b0;
    data_ready = 1'b0;
    self_drop  = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = free;
        if (msg_valid && free) begin
          if (msg_dst == SELF) begin
            self_drop = 1'b1;
          end else begin
            load              = 1'b1;
            load_flit.ftype   = FT_HEADER;
            load_flit.payload = hdr;
            rem_n             = msg_len;
            state_n           = (msg_len != '0) ? BODY : ZTAIL;
          end
        end
      end
      BODY: begin
        data_ready = free;
        if (data_valid && free) begin
          load              = 1'b1;
          load_flit.payload = data;
          load_flit.ftype   = (rem > LEN_W'(1)) ? FT_BODY : FT_TAIL;
          if (rem != '0) rem_n = rem - LEN_W'(1);
          if (rem <= LEN_W'(1)) state_n = IDLE;
        end
      end
      ZTAIL: begin
        // Zero-length packets still need a TAIL so the router releases the path.
        if (free) begin
          load            = 1'b1;
          load_flit.ftype = FT_TAIL;
          state_n         = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      sv       <= 1'b0;
      slot     <= '0;
      err_self <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      err_self <= self_drop;
      if (load) begin
        slot <= load_flit;
        sv   <= 1'b1;
      end else if (out.ack) begin
        sv   <= 1'b0;
      end
    end
  end

  assign out.enable = sv;
  assign out.flit   = slot;
  // The slot only ever holds flits of the packet in flight.
  assign busy       = (state != IDLE) || sv;

endmodule

// File: tb/tb_flit_injector.sv
// Directed self-checking bench for flit_injector: one task per scenario,
// transfers captured by a negedge monitor and compared to hand-built packets.
module tb_flit_injector;
  import flit_injector_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 msg_valid;
  logic                 msg_ready;
  addr_t                msg_dst;
  logic [7:0]           msg_len;
  logic                 data_valid;
  logic                 data_ready;
  logic [PAYLOAD_W-1:0] data;
  logic                 err_self;
  logic                 busy;
  logic                 ack;

  int checks   = 0;
  int failures = 0;

  node_port ifc ();
  assign ifc.ack = ack;

  flit_injector #(.X(1), .Y(1), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_dst(msg_dst), .msg_len(msg_len),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .out(ifc), .err_self(err_self), .busy(busy)
  );

  always #5 clk = ~clk;

  // Link monitor
  flit_t xf_q[$];
  int    xf_cyc[$];
  int    cyc = 0, acc_cyc = 0, dr_cnt = 0, err_cnt = 0, en_cnt = 0, dacc_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ifc.enable && ack) begin
      xf_q.push_back(ifc.flit);
      xf_cyc.push_back(cyc);
    end
    if (msg_valid && msg_ready) acc_cyc = cyc;
    if (data_ready) dr_cnt = dr_cnt + 1;
    if (err_self) err_cnt = err_cnt + 1;
    if (ifc.enable) en_cnt = en_cnt + 1;
    if (data_valid && data_ready) dacc_cnt = dacc_cnt + 1;
  end

  function automatic flit_t mk(input logic [1:0] ft, input logic [PAYLOAD_W-1:0] p);
    flit_t f;
    f.ftype   = ft;
    f.payload = p;
    return f;
  endfunction

  task automatic clear_mon();
    xf_q.delete();
    xf_cyc.delete();
    dr_cnt = 0; err_cnt = 0; en_cnt = 0; dacc_cnt = 0;
  endtask

  task automatic send_msg(input logic [7:0] dst, input logic [7:0] len);
    int n;
    msg_valid = 1'b1;
    msg_dst   = dst;
    msg_len   = len;
    n = 0;
    @(negedge clk);
    while (!msg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      $display("FAIL send_msg_timeout: msg_ready stayed %0b, required 1", msg_ready);
      failures++;
    end
    @(posedge clk); #1;
    msg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [PAYLOAD_W-1:0] w);
    int n;
    data_valid = 1'b1;
    data       = w;
    n = 0;
    @(negedge clk);
    while (!data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      $display("FAIL send_word_timeout: data_ready stayed %0b, required 1", data_ready);
      failures++;
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; msg_valid = 1'b0; data_valid = 1'b0; msg_dst = '0; msg_len = '0;
    data = '0; ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ifc.enable !== 1'b0) begin $display("FAIL reset_enable: got %b want 0", ifc.enable); failures++; end
    checks++; if (ifc.flit !== '0) begin $display("FAIL reset_flit: got %h want 0", ifc.flit); failures++; end
    checks++; if (msg_ready !== 1'b1) begin $display("FAIL reset_msg_ready: got %b want 1", msg_ready); failures++; end
    checks++; if (data_ready !== 1'b0) begin $display("FAIL reset_data_ready: got %b want 0", data_ready); failures++; end
    checks++; if (err_self !== 1'b0) begin $display("FAIL reset_err_self: got %b want 0", err_self); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); failures++; end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_packet();
    flit_t exp[4];
    exp[0] = mk(FT_HEADER, 16'h2100);
    exp[1] = mk(FT_BODY, 16'h000A);
    exp[2] = mk(FT_BODY, 16'h000B);
    exp[3] = mk(FT_TAIL, 16'h000C);
    clear_mon();
    ack = 1'b1;
    send_msg(8'h21, 8'd3);
    checks++; if (busy !== 1'b1) begin $display("FAIL basic_busy_after_accept: got %b want 1", busy); failures++; end
    send_word(16'h000A);
    send_word(16'h000B);
    send_word(16'h000C);
    idle_cycles(3);
    checks++;
    if (xf_q.size() !== 4) begin
      $display("FAIL basic_count: got %0d flits want 4", xf_q.size()); failures++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (xf_q[i] !== exp[i]) begin $display("FAIL basic_flit%0d: got %h want %h", i, xf_q[i], exp[i]); failures++; end
        checks++;
        if (xf_cyc[i] !== acc_cyc + 1 + i) begin
          $display("FAIL basic_cycle%0d: got %0d want %0d", i, xf_cyc[i], acc_cyc + 1 + i); failures++;
        end
      end
    end
    checks++; if (busy !== 1'b0) begin $display("FAIL basic_busy_end: got %b want 0", busy); failures++; end
  endtask

  task automatic test_zero_len();
    flit_t exp[2];
    exp[0] = mk(FT_HEADER, 16'h0100);
    exp[1] = mk(FT_TAIL, 16'h0000);
    clear_mon();
    ack = 1'b1;
    send_msg(8'h01, 8'd0);
    idle_cycles(4);
    checks++;
    if (xf_q.size() !== 2) begin
      $display("FAIL zlen_count: got %0d flits want 2", xf_q.size()); failures++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (xf_q[i] !== exp[i]) begin $display("FAIL zlen_flit%0d: got %h want %h", i, xf_q[i], exp[i]); failures++; end
      end
      checks++;
      if (xf_cyc[1] !== xf_cyc[0] + 1) begin $display("FAIL zlen_consecutive: got %0d want %0d", xf_cyc[1], xf_cyc[0] + 1); failures++; end
    end
    checks++; if (dr_cnt !== 0) begin $display("FAIL zlen_data_ready: got %0d cycles want 0", dr_cnt); failures++; end
  endtask

  task automatic test_self_addr();
    clear_mon();
    ack = 1'b1;
    send_msg(8'h11, 8'd2);
    idle_cycles(4);
    @(negedge clk);
    checks++; if (err_cnt !== 1) begin $display("FAIL self_err_pulse: got %0d cycles want 1", err_cnt); failures++; end
    checks++; if (en_cnt !== 0) begin $display("FAIL self_enable: got %0d cycles want 0", en_cnt); failures++; end
    checks++; if (msg_ready !== 1'b1) begin $display("FAIL self_msg_ready: got %b want 1", msg_ready); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL self_busy: got %b want 0", busy); failures++; end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    flit_t exp[3];
    exp[0] = mk(FT_HEADER, 16'h3200);
    exp[1] = mk(FT_BODY, 16'h0011);
    exp[2] = mk(FT_TAIL, 16'h0022);
    clear_mon();
    ack = 1'b0;
    send_msg(8'h32, 8'd2);
    data_valid = 1'b1;
    data       = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ifc.enable !== 1'b1) begin $display("FAIL bp_enable%0d: got %b want 1", i, ifc.enable); failures++; end
      checks++; if (ifc.flit !== exp[0]) begin $display("FAIL bp_stable%0d: got %h want %h", i, ifc.flit, exp[0]); failures++; end
      checks++; if (data_ready !== 1'b0) begin $display("FAIL bp_data_ready%0d: got %b want 0", i, data_ready); failures++; end
      @(posedge clk); #1;
    end
    checks++; if (dacc_cnt !== 0) begin $display("FAIL bp_consumed: got %0d words want 0", dacc_cnt); failures++; end
    ack = 1'b1;
    send_word(16'h0011);
    send_word(16'h0022);
    idle_cycles(3);
    checks++;
    if (xf_q.size() !== 3) begin
      $display("FAIL bp_count: got %0d flits want 3", xf_q.size()); failures++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xf_q[i] !== exp[i]) begin $display("FAIL bp_flit%0d: got %h want %h", i, xf_q[i], exp[i]); failures++; end
      end
    end
  endtask

  task automatic test_back_to_back();
    flit_t exp[4];
    exp[0] = mk(FT_HEADER, 16'h2200);
    exp[1] = mk(FT_TAIL, 16'h0005);
    exp[2] = mk(FT_HEADER, 16'h2300);
    exp[3] = mk(FT_TAIL, 16'h0006);
    clear_mon();
    ack = 1'b1;
    send_msg(8'h22, 8'd1);
    send_word(16'h0005);
    send_msg(8'h23, 8'd1);
    send_word(16'h0006);
    idle_cycles(3);
    checks++;
    if (xf_q.size() !== 4) begin
      $display("FAIL b2b_count: got %0d flits want 4", xf_q.size()); failures++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (xf_q[i] !== exp[i]) begin $display("FAIL b2b_flit%0d: got %h want %h", i, xf_q[i], exp[i]); failures++; end
        checks++;
        if (xf_cyc[i] !== xf_cyc[0] + i) begin $display("FAIL b2b_cycle%0d: got %0d want %0d", i, xf_cyc[i], xf_cyc[0] + i); failures++; end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    flit_t exp[2];
    flit_t b10;
    b10    = mk(FT_BODY, 16'd10);
    exp[0] = mk(FT_HEADER, 16'h3100);
    exp[1] = mk(FT_TAIL, 16'h0077);
    clear_mon();
    ack = 1'b1;
    send_msg(8'h12, 8'd255);
    for (int i = 1; i <= 10; i++) send_word(16'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (ifc.enable !== 1'b0) begin $display("FAIL rstmid_enable: got %b want 0", ifc.enable); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", busy); failures++; end
    checks++; if (data_ready !== 1'b0) begin $display("FAIL rstmid_data_ready: got %b want 0", data_ready); failures++; end
    checks++; if (msg_ready !== 1'b1) begin $display("FAIL rstmid_msg_ready: got %b want 1", msg_ready); failures++; end
    checks++;
    if (xf_q.size() !== 11) begin
      $display("FAIL rstmid_count: got %0d flits want 11", xf_q.size()); failures++;
    end else begin
      checks++;
      if (xf_q[10] !== b10) begin $display("FAIL rstmid_body10: got %h want %h", xf_q[10], b10); failures++; end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    send_msg(8'h31, 8'd1);
    send_word(16'h0077);
    idle_cycles(3);
    checks++;
    if (xf_q.size() !== 2) begin
      $display("FAIL rstmid_new_count: got %0d flits want 2", xf_q.size()); failures++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (xf_q[i] !== exp[i]) begin $display("FAIL rstmid_new_flit%0d: got %h want %h", i, xf_q[i], exp[i]); failures++; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_zero_len();
    test_self_addr();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
